// File: rtl/ifa_pkg.sv
// Shared types for the ifa bus memory target: command modes, FSM states, mode decoders.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ifa_pkg;

  typedef enum logic [1:0] {
    MODE_RD  = 2'b00,
    MODE_WR  = 2'b01,
    MODE_BRD = 2'b10,
    MODE_BWR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT,
    DATA
  } state_e;

  function automatic logic is_burst(mode_e m);
    return (m == MODE_BRD) || (m == MODE_BWR);
  endfunction

  function automatic logic is_write(mode_e m);
    return (m == MODE_WR) || (m == MODE_BWR);
  endfunction

endpackage

// File: rtl/ifa_mem_slave_if.sv
// ifa bus bundle between the cpucore master and a memory target.
// Latency: n/a (wires only).
// Backpressure: target paces every beat with rdy; the master has no stall input.
interface ifa_mem_slave_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          gnt;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdy;

  modport master (
    output req, start, mode, addr, wdata,
    input  gnt, rdata, rdy
  );

  modport slave (
    input  req, start, mode, addr, wdata,
    output gnt, rdata, rdy
  );
endinterface

// File: rtl/ifa_mem_array.sv
// Byte-addressable storage behind the ifa target, 2**AW entries of DW bits.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; accepts a write every cycle.
module ifa_mem_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Contents are deliberately not reset; a reset mid-burst must not disturb written bytes.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/ifa_mem_slave.sv
// ifa bus memory target: grants req, takes one command, serves single or burst beats.
// Latency: first rdy WAIT_CYCLES+1 cycles after start is sampled, then one beat per cycle.
// Backpressure: none from the master; the target owns beat timing, master follows rdy.
module ifa_mem_slave
  import ifa_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int BURST_LEN   = 4
) (
  input logic            clk,
  input logic            rst_n,
  ifa_mem_slave_if.slave bus
);

  localparam int CW  = $clog2(BURST_LEN);
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e          r_state;
  state_e          w_state_nxt;
  mode_e           r_mode;
  mode_e           w_mode_nxt;
  logic [AW-1:0]   r_cur_addr;
  logic [AW-1:0]   w_addr_nxt;
  logic [CW-1:0]   r_beat_cnt;
  logic [CW-1:0]   w_beat_nxt;
  logic [CW-1:0]   w_last_idx;
  logic [WCW-1:0]  r_wait_cnt;
  logic [WCW-1:0]  w_wait_nxt;
  logic            w_we;
  logic [DW-1:0]   w_mem_rdata;

  logic            r_gnt;
  logic            r_rdy;
  logic [DW-1:0]   r_rdata;

  assign w_last_idx = is_burst(r_mode) ? CW'(BURST_LEN - 1) : '0;

  // Next-state, counter and write-enable decode for the bus FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_addr_nxt  = r_cur_addr;
    w_beat_nxt  = r_beat_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) w_state_nxt = GRANT;
      end
      GRANT: begin
        // A command in the same cycle as a req drop still wins.
        if (bus.start) begin
          w_mode_nxt  = mode_e'(bus.mode);
          w_addr_nxt  = bus.addr;
          w_beat_nxt  = '0;
          w_wait_nxt  = '0;
          w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : DATA;
        end else if (!bus.req) begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_wait_cnt == WCW'(WAIT_CYCLES - 1)) w_state_nxt = DATA;
        else                                     w_wait_nxt  = r_wait_cnt + 1'b1;
      end
      DATA: begin
        w_we       = is_write(r_mode);
        w_addr_nxt = r_cur_addr + 1'b1;
        w_beat_nxt = r_beat_cnt + 1'b1;
        if (r_beat_cnt == w_last_idx) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and command context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mode     <= MODE_RD;
      r_cur_addr <= '0;
      r_beat_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_cur_addr <= w_addr_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // w_addr_nxt is always the address of the beat about to be presented, so it doubles as
  // the read address that lets rdata be registered alongside rdy.
  ifa_mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_cur_addr),
    .wdata (bus.wdata),
    .raddr (w_addr_nxt),
    .rdata (w_mem_rdata)
  );

  // Outputs registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= 1'b0;
      r_rdy   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_gnt   <= (w_state_nxt != IDLE);
      r_rdy   <= (w_state_nxt == DATA);
      r_rdata <= ((w_state_nxt == DATA) && !is_write(w_mode_nxt)) ? w_mem_rdata : '0;
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.rdy   = r_rdy;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_ifa_mem_slave.sv
// Bench for ifa_mem_slave: one instance with one wait state, one with none.
// Latency: checks first-beat timing, beat spacing and re-grant spacing.
// Backpressure: master side only follows rdy; no stall exists to exercise.
module tb_ifa_mem_slave;

  localparam int BL = 4;

  logic clk;
  logic rst_n;

  logic       req_s   [2];
  logic       start_s [2];
  logic [1:0] mode_s  [2];
  logic [7:0] addr_s  [2];
  logic [7:0] wdata_s [2];
  logic       gnt_w   [2];
  logic       rdy_w   [2];
  logic [7:0] rdata_w [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ifa_mem_slave_if #(.AW(8), .DW(8)) bus_a ();
  ifa_mem_slave_if #(.AW(8), .DW(8)) bus_b ();

  assign bus_a.req   = req_s[0];
  assign bus_a.start = start_s[0];
  assign bus_a.mode  = mode_s[0];
  assign bus_a.addr  = addr_s[0];
  assign bus_a.wdata = wdata_s[0];
  assign gnt_w[0]    = bus_a.gnt;
  assign rdy_w[0]    = bus_a.rdy;
  assign rdata_w[0]  = bus_a.rdata;

  assign bus_b.req   = req_s[1];
  assign bus_b.start = start_s[1];
  assign bus_b.mode  = mode_s[1];
  assign bus_b.addr  = addr_s[1];
  assign bus_b.wdata = wdata_s[1];
  assign gnt_w[1]    = bus_b.gnt;
  assign rdy_w[1]    = bus_b.rdy;
  assign rdata_w[1]  = bus_b.rdata;

  ifa_mem_slave #(.AW(8), .DW(8), .WAIT_CYCLES(1), .BURST_LEN(BL)) u_dut_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ifa_mem_slave #(.AW(8), .DW(8), .WAIT_CYCLES(0), .BURST_LEN(BL)) u_dut_w0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference ----------------
  // A command is a list of beats scheduled after the wait time; the model only tracks whether
  // the bus is on offer, how many beats remain and how long until the next one.
  logic [7:0] mm [2][256];
  bit         mk [2][256];
  bit         m_granted [2] = '{0, 0};
  int         m_left    [2] = '{0, 0};
  int         m_wait    [2] = '{0, 0};
  bit         m_wr      [2] = '{0, 0};
  logic [7:0] m_addr    [2];
  logic [7:0] m_waddr   [2];
  bit         m_gnt     [2] = '{0, 0};
  bit         m_rdy     [2] = '{0, 0};
  logic [7:0] m_rdata   [2] = '{8'h00, 8'h00};
  bit         m_rkn     [2] = '{1, 1};

  function automatic int wc(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_granted[d] = 0; m_left[d] = 0; m_wait[d] = 0;
        m_gnt[d] = 0; m_rdy[d] = 0; m_rdata[d] = 8'h00; m_rkn[d] = 1;
      end else begin
        if (m_rdy[d] && m_wr[d]) begin
          mm[d][m_waddr[d]] = wdata_s[d];
          mk[d][m_waddr[d]] = 1;
        end
        if (m_granted[d] && start_s[d]) begin
          m_granted[d] = 0;
          m_left[d]    = mode_s[d][1] ? BL : 1;
          m_wr[d]      = mode_s[d][0];
          m_addr[d]    = addr_s[d];
          m_wait[d]    = wc(d);
        end else if (m_granted[d] && !req_s[d]) begin
          m_granted[d] = 0;
        end else if (!m_gnt[d] && req_s[d]) begin
          m_granted[d] = 1;
        end
        m_rdy[d] = 0; m_rdata[d] = 8'h00; m_rkn[d] = 1;
        if (m_left[d] > 0) begin
          if (m_wait[d] > 0) m_wait[d]--;
          else begin
            m_rdy[d]   = 1;
            m_waddr[d] = m_addr[d];
            if (!m_wr[d]) begin
              m_rdata[d] = mm[d][m_addr[d]];
              m_rkn[d]   = mk[d][m_addr[d]];
            end
            m_addr[d] = m_addr[d] + 8'd1;
            m_left[d]--;
          end
        end
        m_gnt[d] = m_granted[d] || (m_left[d] > 0) || m_rdy[d];
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Every-cycle comparison of both instances against the reference.
  initial forever begin
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("cyc_gnt[%0d]", d), 32'(gnt_w[d]), 32'(m_gnt[d]));
      chk($sformatf("cyc_rdy[%0d]", d), 32'(rdy_w[d]), 32'(m_rdy[d]));
      if (m_rkn[d]) chk($sformatf("cyc_rdata[%0d]", d), 32'(rdata_w[d]), 32'(m_rdata[d]));
    end
  end

  // ---------------- stimulus ----------------
  // ev: 0 none, 1 drop req after beat 2, 2 pulse reset during beat 2.
  task automatic cmd(input int d, input logic [1:0] md, input logic [7:0] a,
                     input logic [31:0] wd, input int ev, input bit keep,
                     output int first_off, output int t_start, output int t_first,
                     output int t_last, output logic [31:0] rd, output int nb);
    int  nbx;
    int  g;
    bit  stop;
    nbx = md[1] ? BL : 1;
    req_s[d] = 1'b1;
    g = 0;
    while (!gnt_w[d] && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!gnt_w[d]) chk("grant_wait", 32'(gnt_w[d]), 32'd1);
    start_s[d] = 1'b1; mode_s[d] = md; addr_s[d] = a; t_start = cyc;
    @(negedge clk);
    start_s[d] = 1'b0;
    nb = 0; g = 0; rd = '0; t_first = -1; t_last = -1; stop = 0;
    while (nb < nbx && g < 20 && !stop) begin
      if (rdy_w[d]) begin
        if (nb == 0) t_first = cyc;
        t_last = cyc;
        rd[8*nb +: 8] = rdata_w[d];
        wdata_s[d]    = wd[8*nb +: 8];
        nb++;
        if (nb == nbx && !keep) req_s[d] = 1'b0;
        if (nb == 2 && ev == 1) req_s[d] = 1'b0;
        if (nb == 2 && ev == 2) begin
          rst_n = 1'b0;
          #1;
          chk("midrst_gnt",   32'(gnt_w[d]),   32'd0);
          chk("midrst_rdy",   32'(rdy_w[d]),   32'd0);
          chk("midrst_rdata", 32'(rdata_w[d]), 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
          req_s[d] = 1'b0;
          stop = 1;
        end
      end
      if (!stop) begin
        @(negedge clk);
        g++;
      end
    end
    if (nb < nbx && !stop) chk("beat_wait", 32'(nb), 32'(nbx));
    first_off = t_first - t_start;
  endtask

  initial begin
    int fo, ts, tf, tl, nb, tf1;
    logic [31:0] rd;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 1'b1; start_s[d] = 1'b1; mode_s[d] = 2'b00;
      addr_s[d] = 8'h00; wdata_s[d] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_gnt",   32'(gnt_w[0]),   32'd0);
    chk("rst_rdy",   32'(rdy_w[0]),   32'd0);
    chk("rst_rdata", 32'(rdata_w[0]), 32'd0);
    rst_n = 1'b1; start_s[0] = 1'b0; start_s[1] = 1'b0;
    #1 chk("rel_gnt_now", 32'(gnt_w[0]), 32'd0);
    @(negedge clk);
    chk("rel_gnt_next", 32'(gnt_w[0]), 32'd1);
    req_s[1] = 1'b0;

    // single write then read, one wait state
    cmd(0, 2'b01, 8'hAA, 32'h5C, 0, 0, fo, ts, tf, tl, rd, nb);
    chk("wr_lat", 32'(fo), 32'd2);
    cmd(0, 2'b00, 8'hAA, 32'h0, 0, 0, fo, ts, tf, tl, rd, nb);
    chk("rd_lat",  32'(fo), 32'd2);
    chk("rd_data", rd, 32'h5C);

    // burst write across the top of memory, then read back
    cmd(0, 2'b11, 8'hFE, 32'h44332211, 0, 0, fo, ts, tf, tl, rd, nb);
    chk("bwr_beats",  32'(nb),      32'd4);
    chk("bwr_consec", 32'(tl - tf), 32'd3);
    cmd(0, 2'b10, 8'hFE, 32'h0, 0, 0, fo, ts, tf, tl, rd, nb);
    chk("brd_lat",  32'(fo), 32'd2);
    chk("brd_data", rd,      32'h44332211);

    // grant offered then withdrawn without a command
    @(negedge clk);
    chk("gw_idle", 32'(gnt_w[0]), 32'd0);
    req_s[0] = 1'b1;
    @(negedge clk);
    chk("gw_g1", 32'(gnt_w[0]), 32'd1);
    @(negedge clk);
    chk("gw_g2", 32'(gnt_w[0]), 32'd1);
    req_s[0] = 1'b0;
    @(negedge clk);
    chk("gw_drop", 32'(gnt_w[0]), 32'd0);

    // req dropped mid burst read: all beats still delivered, memory untouched
    cmd(0, 2'b10, 8'hFE, 32'h0, 1, 0, fo, ts, tf, tl, rd, nb);
    chk("reqdrop_beats", 32'(nb), 32'd4);
    chk("reqdrop_data",  rd,      32'h44332211);

    // reset during beat 2 of a burst write
    cmd(0, 2'b11, 8'h10, 32'hA3A2A1A0, 0, 0, fo, ts, tf, tl, rd, nb);
    cmd(0, 2'b11, 8'h10, 32'hB3B2B1B0, 2, 0, fo, ts, tf, tl, rd, nb);
    chk("midrst_beats", 32'(nb), 32'd2);
    cmd(0, 2'b10, 8'h10, 32'h0, 0, 0, fo, ts, tf, tl, rd, nb);
    chk("midrst_mem", rd, 32'hA3A2A1B0);

    // zero-wait instance: latency and back-to-back re-grant spacing
    cmd(1, 2'b01, 8'h33, 32'h7E, 0, 0, fo, ts, tf, tl, rd, nb);
    chk("w0_wr_lat", 32'(fo), 32'd1);
    cmd(1, 2'b00, 8'h33, 32'h0, 0, 1, fo, ts, tf, tl, rd, nb);
    chk("w0_rd1_lat",  32'(fo), 32'd1);
    chk("w0_rd1_data", rd,      32'h7E);
    tf1 = tf;
    cmd(1, 2'b00, 8'h33, 32'h0, 0, 0, fo, ts, tf, tl, rd, nb);
    chk("w0_regrant",  32'(ts - tf1), 32'd2);
    chk("w0_rd2_data", rd,            32'h7E);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
